rsfq_merge_sync: RTL and testbench

- Synchronous, clocked model of an RSFQ timed merge cell (merge-T).
- Inputs `a` and `b` are toggle-encoded pulse streams: every level change is one pulse.
- Output `out` is toggle-encoded: it toggles once per merged pulse after a fixed latency.
- Sits between pulse-domain logic models and synchronous checkers/consumers.

---
 rtl/rsfq_merge_pkg.sv | 15 +
 rtl/rsfq_toggle_detect.sv | 17 +
 rtl/rsfq_merge_sync.sv | 111 +++++++++++
 tb/tb_rsfq_merge_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsfq_merge_pkg.sv
// Shared defaults and sizing helpers for the RSFQ timed merge model.
package rsfq_merge_pkg;

    localparam int DELAY_DEF   = 2;
    localparam int HOLDOFF_DEF = 0;
    localparam int CNT_W_DEF   = 8;

    // Holdoff counter must hold HOLDOFF itself; never narrower than one bit.
    function automatic int hold_w(input int holdoff);
        int w;
        w = $clog2(holdoff + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rsfq_toggle_detect.sv
// Toggle-encoded pulse detector: a level register plus XOR against the live input.
module rsfq_toggle_detect (
    input  logic clk_i,
    input  logic lvl_i,
    output logic pulse_o
);

    logic lvl_q;

    // Tracks the input during reset as well, so levels held through reset never look like a pulse.
    always_ff @(posedge clk_i) begin
        lvl_q <= lvl_i;
    end

    assign pulse_o = lvl_i ^ lvl_q;

endmodule

// File: rtl/rsfq_merge_sync.sv
// Clocked merge-T model: merges toggle-encoded pulses on a and b into one delayed toggle stream.
// Optional absorbed-pulse counter enabled by defining MERGET_DROP_CNT_EN.
module rsfq_merge_sync
    import rsfq_merge_pkg::*;
#(
    parameter int DELAY   = DELAY_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic a_i,
    input  logic b_i,
    output logic out_o
`ifdef MERGET_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] drop_cnt_o
`endif
);

    localparam int HW = hold_w(HOLDOFF);

    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $error("rsfq_merge_sync: DELAY must be 1..16");
    end
    if (HOLDOFF < 0 || HOLDOFF > 255) begin : g_bad_holdoff
        $error("rsfq_merge_sync: HOLDOFF must be 0..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("rsfq_merge_sync: CNT_W must be at least 1");
    end

    logic          pa, pb, ev, accept, tail;
    logic [HW-1:0] hold_q, hold_d;
    logic          out_q, out_d;

    rsfq_toggle_detect u_det_a (.clk_i(clk_i), .lvl_i(a_i), .pulse_o(pa));
    rsfq_toggle_detect u_det_b (.clk_i(clk_i), .lvl_i(b_i), .pulse_o(pb));

    assign ev     = pa | pb;
    assign accept = ev && (hold_q == '0);

    always_comb begin
        hold_d = hold_q;
        if (accept) begin
            hold_d = HW'(HOLDOFF);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    // out_q is the last pipeline stage, so only DELAY-1 request stages sit ahead of it.
    if (DELAY == 1) begin : g_pipe_none
        assign tail = accept;
    end else begin : g_pipe
        logic [DELAY-2:0] pipe_q, pipe_d;

        assign pipe_d = (pipe_q << 1) | (DELAY - 1)'(accept);
        assign tail   = pipe_q[DELAY-2];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end
    end

    assign out_d = out_q ^ tail;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;

`ifdef MERGET_DROP_CNT_EN
    logic             drop_inc;
    logic [CNT_W-1:0] drop_q, drop_d;

    // A blocked event counts once; an accepted coincidence loses its second pulse.
    assign drop_inc = (ev && !accept) || (accept && pa && pb);

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;
`else
    // Without the counter, coincident and held-off pulses are merged silently.
`endif

endmodule

// File: tb/tb_rsfq_merge_sync.sv
// Bench for rsfq_merge_sync: directed table plus random stimulus against a scheduled-toggle model.
module tb_rsfq_merge_sync;

    localparam int ND = 4;
    localparam int DL [ND] = '{2, 2, 4, 1};
    localparam int HO [ND] = '{0, 3, 0, 2};
    localparam int CAP = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] rst_v, a_v, b_v, out_v;
`ifdef MERGET_DROP_CNT_EN
    logic [7:0] drop_w [ND];
`endif

    int total = 0;
    int bad   = 0;

    rsfq_merge_sync #(.DELAY(2), .HOLDOFF(0), .CNT_W(8)) u0 (
        .clk_i(clk), .rst_i(rst_v[0]), .a_i(a_v[0]), .b_i(b_v[0]), .out_o(out_v[0])
`ifdef MERGET_DROP_CNT_EN
        , .drop_cnt_o(drop_w[0])
`endif
    );
    rsfq_merge_sync #(.DELAY(2), .HOLDOFF(3), .CNT_W(8)) u1 (
        .clk_i(clk), .rst_i(rst_v[1]), .a_i(a_v[1]), .b_i(b_v[1]), .out_o(out_v[1])
`ifdef MERGET_DROP_CNT_EN
        , .drop_cnt_o(drop_w[1])
`endif
    );
    rsfq_merge_sync #(.DELAY(4), .HOLDOFF(0), .CNT_W(8)) u2 (
        .clk_i(clk), .rst_i(rst_v[2]), .a_i(a_v[2]), .b_i(b_v[2]), .out_o(out_v[2])
`ifdef MERGET_DROP_CNT_EN
        , .drop_cnt_o(drop_w[2])
`endif
    );
    rsfq_merge_sync #(.DELAY(1), .HOLDOFF(2), .CNT_W(8)) u3 (
        .clk_i(clk), .rst_i(rst_v[3]), .a_i(a_v[3]), .b_i(b_v[3]), .out_o(out_v[3])
`ifdef MERGET_DROP_CNT_EN
        , .drop_cnt_o(drop_w[3])
`endif
    );

    // Reference model: each accepted event at edge k schedules an output toggle at edge k+DELAY-1.
    int cyc = 0;
    bit m_la [ND];
    bit m_lb [ND];
    bit m_out [ND];
    int m_hold [ND];
    int m_drop [ND];
    int sched [ND][$];

    always @(posedge clk) begin
        bit pa, pb;
        cyc++;
        for (int i = 0; i < ND; i++) begin
            if (rst_v[i]) begin
                m_out[i]  = 1'b0;
                m_hold[i] = 0;
                m_drop[i] = 0;
                sched[i].delete();
            end else begin
                pa = a_v[i] ^ m_la[i];
                pb = b_v[i] ^ m_lb[i];
                if (pa || pb) begin
                    if (m_hold[i] == 0) begin
                        sched[i].push_back(cyc + DL[i] - 1);
                        m_hold[i] = HO[i];
                        if (pa && pb && m_drop[i] < CAP) m_drop[i]++;
                    end else begin
                        m_hold[i]--;
                        if (m_drop[i] < CAP) m_drop[i]++;
                    end
                end else if (m_hold[i] > 0) begin
                    m_hold[i]--;
                end
                if (sched[i].size() > 0 && sched[i][0] == cyc) begin
                    m_out[i] = ~m_out[i];
                    void'(sched[i].pop_front());
                end
            end
            m_la[i] = a_v[i];
            m_lb[i] = b_v[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            total++;
            if (out_v[i] !== m_out[i]) begin
                bad++;
                $display("FAIL model_out dut%0d edge=%0d got=%b want=%b", i, cyc, out_v[i], m_out[i]);
            end
`ifdef MERGET_DROP_CNT_EN
            total++;
            if (drop_w[i] !== 8'(m_drop[i])) begin
                bad++;
                $display("FAIL model_drop dut%0d edge=%0d got=%0d want=%0d", i, cyc, drop_w[i], m_drop[i]);
            end
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic chk_drop(input string name, input int idx, input int want);
`ifdef MERGET_DROP_CNT_EN
        total++;
        if (drop_w[idx] !== 8'(want)) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, cyc, drop_w[idx], want);
        end
`endif
    endtask

    typedef struct {
        logic rst;
        logic a;
        logic b;
        logic exp_out;
        int   exp_drop;
    } vec_t;

    vec_t tbl [26];

    initial begin
        rst_v = '1;
        a_v   = '0;
        b_v   = '0;

        // Row i drives the inputs sampled at edge i; expectations hold just after that edge.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
        for (int i = 16; i < 26; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};

        for (int i = 0; i < 26; i++) begin
            rst_v[0] = tbl[i].rst;
            a_v[0]   = tbl[i].a;
            b_v[0]   = tbl[i].b;
            tick();
            chk("table_out", out_v[0], tbl[i].exp_out);
            chk_drop("table_drop", 0, tbl[i].exp_drop);
        end

        // Holdoff 3: b inside the window is absorbed, b after it is accepted.
        rst_v[1] = 1'b0;
        tick();
        tick();
        a_v[1] = 1'b1;
        tick(); chk("hold_e0", out_v[1], 1'b0);
        tick(); chk("hold_e1", out_v[1], 1'b1);
        b_v[1] = 1'b1;
        tick(); chk("hold_e2", out_v[1], 1'b1); chk_drop("hold_drop", 1, 1);
        tick(); chk("hold_e3", out_v[1], 1'b1);
        tick(); chk("hold_e4", out_v[1], 1'b1);
        b_v[1] = 1'b0;
        tick(); chk("hold_e5", out_v[1], 1'b1);
        tick(); chk("hold_e6", out_v[1], 1'b0); chk_drop("hold_drop_end", 1, 1);

        // Delay 4: reset two edges after the pulse kills the in-flight toggle.
        rst_v[2] = 1'b0;
        tick();
        a_v[2] = 1'b1;
        tick(); chk("flight_e0", out_v[2], 1'b0);
        tick(); chk("flight_e1", out_v[2], 1'b0);
        rst_v[2] = 1'b1;
        tick(); chk("flight_rst", out_v[2], 1'b0);
        rst_v[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(); chk("flight_after", out_v[2], 1'b0);
        end

        // Back-to-back accepted toggles on a, holdoff 0.
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) a_v[0] = ~a_v[0];
            tick();
            chk("burst_out", out_v[0], (k >= 1 && k <= 8) ? logic'(k % 2) : 1'b0);
        end
        chk_drop("burst_drop", 0, 0);

        // Random traffic on all four configurations, with occasional resets.
        rst_v = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < ND; i++) begin
                rst_v[i] = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 2) == 0) a_v[i] = ~a_v[i];
                if ($urandom_range(0, 2) == 0) b_v[i] = ~b_v[i];
            end
            tick();
        end
        rst_v = '0;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
